// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants plus the test-pattern bar
// lookup shared by the timing generator and its users.
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  localparam logic [9:0] BAR_W     = 10'd80;

  // Inclusive sync-pulse bounds derived from the porch/sync widths
  localparam logic [9:0] H_SYNC_FIRST = H_VISIBLE + H_FP;                  // 656
  localparam logic [9:0] H_SYNC_LAST  = H_VISIBLE + H_FP + H_SYNC - 10'd1; // 751
  localparam logic [9:0] V_SYNC_FIRST = V_VISIBLE + V_FP;                  // 490
  localparam logic [9:0] V_SYNC_LAST  = V_VISIBLE + V_FP + V_SYNC - 10'd1; // 491

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Bar index as x/80, built from a comparator chain instead of a divider
  function automatic bar_e bar_of(input logic [9:0] x);
    if      (x < BAR_W)          return BAR_WHITE;
    else if (x < BAR_W * 10'd2)  return BAR_YELLOW;
    else if (x < BAR_W * 10'd3)  return BAR_CYAN;
    else if (x < BAR_W * 10'd4)  return BAR_GREEN;
    else if (x < BAR_W * 10'd5)  return BAR_MAGENTA;
    else if (x < BAR_W * 10'd6)  return BAR_RED;
    else if (x < BAR_W * 10'd7)  return BAR_BLUE;
    else                         return BAR_BLACK;
  endfunction

  function automatic rgb_t bar_colour(input bar_e bar);
    rgb_t c;
    c = '0;
    case (bar)
      BAR_WHITE:   c = '{r: 4'hF, g: 4'hF, b: 4'hF};
      BAR_YELLOW:  c = '{r: 4'hF, g: 4'hF, b: 4'h0};
      BAR_CYAN:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
      BAR_GREEN:   c = '{r: 4'h0, g: 4'hF, b: 4'h0};
      BAR_MAGENTA: c = '{r: 4'hF, g: 4'h0, b: 4'hF};
      BAR_RED:     c = '{r: 4'hF, g: 4'h0, b: 4'h0};
      BAR_BLUE:    c = '{r: 4'h0, g: 4'h0, b: 4'hF};
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: bundle of the timing generator's outputs; master drives,
// slave (display pipeline / monitor) observes.
interface vga_timing_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        blank_d;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic [15:0] frame_count;
  logic [3:0]  tp_red;
  logic [3:0]  tp_green;
  logic [3:0]  tp_blue;

  modport master (
    output DrawX, DrawY, blank, blank_d, hs, vs,
    output frame_start, frame_count, tp_red, tp_green, tp_blue
  );

  modport slave (
    input DrawX, DrawY, blank, blank_d, hs, vs,
    input frame_start, frame_count, tp_red, tp_green, tp_blue
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-TOTAL counter for one screen axis with enable,
// wrap flag and synchronous active-high reset.
module vga_axis_counter #(
  parameter int unsigned    W     = 10,
  parameter logic [W-1:0]   TOTAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last  = (r_count == TOTAL - 1'b1);
  assign o_wrap  = i_en & w_last;
  assign o_count = r_count;

  // Step on enable, returning to zero after TOTAL-1
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_count <= '0;
    else if (i_en)   r_count <= w_last ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (DrawX/DrawY, blank, syncs with a
// SYNC_DELAY-deep alignment line, frame pulse/counter).
// Optional test-pattern bars are built when VGA_TESTPAT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  // Cycles hs/vs/blank_d lag DrawX/DrawY; intended range 0..4
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        blank_d,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic [3:0]  tp_red,
  output logic [3:0]  tp_green,
  output logic [3:0]  tp_blue
);

  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_blank;
  logic        w_hs;
  logic        w_vs;
  logic [15:0] r_frame_count;

  vga_axis_counter #(.W(10), .TOTAL(H_TOTAL)) u_hcnt (
    .i_clk   (vga_clk),
    .i_rst   (reset),
    .i_en    (1'b1),
    .o_count (w_x),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(.W(10), .TOTAL(V_TOTAL)) u_vcnt (
    .i_clk   (vga_clk),
    .i_rst   (reset),
    .i_en    (w_h_wrap),
    .o_count (w_y),
    .o_wrap  (w_v_wrap)
  );

  // Undelayed raster decode; blank is held low while reset is asserted
  assign w_blank = !reset && (w_x < H_VISIBLE) && (w_y < V_VISIBLE);
  assign w_hs    = !((w_x >= H_SYNC_FIRST) && (w_x <= H_SYNC_LAST));
  assign w_vs    = !((w_y >= V_SYNC_FIRST) && (w_y <= V_SYNC_LAST));

  assign DrawX       = w_x;
  assign DrawY       = w_y;
  assign blank       = w_blank;
  assign frame_start = !reset && (w_x == '0) && (w_y == '0);
  assign frame_count = r_frame_count;

  // Count a frame only on the natural (799,524)->(0,0) step
  always_ff @(posedge vga_clk) begin
    if (reset)         r_frame_count <= '0;
    else if (w_v_wrap) r_frame_count <= r_frame_count + 1'b1;
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hs      = w_hs;
      assign vs      = w_vs;
      assign blank_d = w_blank;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] r_hs_line;
      logic [SYNC_DELAY-1:0] r_vs_line;
      logic [SYNC_DELAY-1:0] r_blank_line;

      // Shift line; stage 0 takes the undelayed value, last stage drives out
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          r_hs_line    <= '1;
          r_vs_line    <= '1;
          r_blank_line <= '0;
        end else begin
          r_hs_line[0]    <= w_hs;
          r_vs_line[0]    <= w_vs;
          r_blank_line[0] <= w_blank;
          for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
            r_hs_line[i]    <= r_hs_line[i-1];
            r_vs_line[i]    <= r_vs_line[i-1];
            r_blank_line[i] <= r_blank_line[i-1];
          end
        end
      end

      assign hs      = r_hs_line[SYNC_DELAY-1];
      assign vs      = r_vs_line[SYNC_DELAY-1];
      assign blank_d = r_blank_line[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_TESTPAT_EN
  rgb_t r_tp;

  // Colour bars registered one cycle behind DrawX, dark outside the visible area
  always_ff @(posedge vga_clk) begin
    if (reset || !w_blank) r_tp <= '0;
    else                   r_tp <= bar_colour(bar_of(w_x));
  end

  assign tp_red   = r_tp.r;
  assign tp_green = r_tp.g;
  assign tp_blue  = r_tp.b;
`else
  assign tp_red   = 4'h0;
  assign tp_green = 4'h0;
  assign tp_blue  = 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench with a cycle model of the raster and a
// queue of expected sync/blank_d values released SD cycles after they are produced.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int unsigned SD = 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bd;
  } sync_t;

  localparam sync_t RST_SYNC = '{hs: 1'b1, vs: 1'b1, bd: 1'b0};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #20 vga_clk = ~vga_clk;

  vga_timing_if vif ();
  vga_timing_if vif0 ();

  vga_timing_gen #(.SYNC_DELAY(SD)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (vif.DrawX),
    .DrawY       (vif.DrawY),
    .blank       (vif.blank),
    .blank_d     (vif.blank_d),
    .hs          (vif.hs),
    .vs          (vif.vs),
    .frame_start (vif.frame_start),
    .frame_count (vif.frame_count),
    .tp_red      (vif.tp_red),
    .tp_green    (vif.tp_green),
    .tp_blue     (vif.tp_blue)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut0 (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (vif0.DrawX),
    .DrawY       (vif0.DrawY),
    .blank       (vif0.blank),
    .blank_d     (vif0.blank_d),
    .hs          (vif0.hs),
    .vs          (vif0.vs),
    .frame_start (vif0.frame_start),
    .frame_count (vif0.frame_count),
    .tp_red      (vif0.tp_red),
    .tp_green    (vif0.tp_green),
    .tp_blue     (vif0.tp_blue)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned mx, my;
  logic [15:0] mfc;
  logic [11:0] mtp;
  sync_t       sb[$];
  int unsigned since_fs;
  int unsigned hs_low, hs_first, hs0_first, vs_low, blank_low;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic sync_t und(input int unsigned x, input int unsigned y, input logic rst);
    sync_t s;
    s.hs = !(x >= 656 && x <= 751);
    s.vs = !(y >= 490 && y <= 491);
    s.bd = !rst && (x < 640) && (y < 480);
    return s;
  endfunction

  function automatic logic [11:0] tp_of(input int unsigned x);
    case (x / 80)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // One clock: model the edge, then compare every output against the model
  task automatic tick();
    sync_t       u, e, cur;
    logic        r;
    logic [11:0] tp_next;
    u = und(mx, my, reset);
    r = reset;
`ifdef VGA_TESTPAT_EN
    tp_next = u.bd ? tp_of(mx) : 12'h000;
`else
    tp_next = 12'h000;
`endif
    @(posedge vga_clk);
    #1;
    if (r) begin
      mx = 0; my = 0; mfc = '0; mtp = '0;
      sb.delete();
      for (int i = 1; i < int'(SD); i++) sb.push_back(RST_SYNC);
      e = RST_SYNC;
    end else begin
      sb.push_back(u);
      e   = sb.pop_front();
      mtp = tp_next;
      if (mx == 799) begin
        mx = 0;
        if (my == 524) begin my = 0; mfc = mfc + 16'd1; end
        else my = my + 1;
      end else mx = mx + 1;
    end
    since_fs++;
    cur = und(mx, my, reset);
    chk("drawx", 32'(vif.DrawX), mx);
    chk("drawy", 32'(vif.DrawY), my);
    chk("blank", 32'(vif.blank), 32'(cur.bd));
    chk("frame_start", 32'(vif.frame_start), 32'(!reset && mx == 0 && my == 0));
    chk("frame_count", 32'(vif.frame_count), 32'(mfc));
    chk("hs", 32'(vif.hs), 32'(e.hs));
    chk("vs", 32'(vif.vs), 32'(e.vs));
    chk("blank_d", 32'(vif.blank_d), 32'(e.bd));
    chk("tp", 32'({vif.tp_red, vif.tp_green, vif.tp_blue}), 32'(mtp));
    if (!vif.hs) begin
      hs_low++;
      if (hs_first == 1023) hs_first = mx;
    end
    if (!vif0.hs && hs0_first == 1023) hs0_first = mx;
    if (!vif.vs) vs_low++;
    if (!vif.blank) blank_low++;
    if (vif.frame_start) begin
      chk("frame_period", since_fs, 420000);
      since_fs = 0;
    end
  endtask

  task automatic run_to(input int unsigned x, input int unsigned y, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(mx == x && my == y)) begin
      if (n >= budget) begin
        n_tests++;
        n_fail++;
        $error("FAIL run_to: observed timeout at (%0d,%0d) expected (%0d,%0d)", mx, my, x, y);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Jump the vertical counter forward at the start of a line (mx must be 0)
  task automatic poke_row(input int unsigned y1);
    since_fs += (y1 - my) * 800;
    dut.u_vcnt.r_count = 10'(y1);
    my = y1;
  endtask

  initial begin
    mx = 0; my = 0; mfc = '0; mtp = '0; since_fs = 0;
    hs_low = 0; hs_first = 1023; hs0_first = 1023; vs_low = 0; blank_low = 0;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_hs", 32'(vif.hs), 1);
    chk("rst_fc", 32'(vif.frame_count), 0);

    reset = 1'b0;
    #1;
    chk("rel_x", 32'(vif.DrawX), 0);
    chk("rel_blank", 32'(vif.blank), 1);
    chk("rel_fs", 32'(vif.frame_start), 1);
    since_fs = 0; hs_low = 0; hs_first = 1023; hs0_first = 1023; blank_low = 0;

    for (int i = 0; i < 800; i++) begin
      tick();
`ifdef VGA_TESTPAT_EN
      if (mx == 86)  chk("tp_x85",  32'({vif.tp_red, vif.tp_green, vif.tp_blue}), 32'h0FF0);
`else
      if (mx == 86)  chk("tp_x85",  32'({vif.tp_red, vif.tp_green, vif.tp_blue}), 32'h0000);
`endif
      if (mx == 601) chk("tp_x600", 32'({vif.tp_red, vif.tp_green, vif.tp_blue}), 32'h0000);
      if (mx == 701) chk("tp_x700", 32'({vif.tp_red, vif.tp_green, vif.tp_blue}), 32'h0000);
    end
    chk("line_x", 32'(vif.DrawX), 0);
    chk("line_y", 32'(vif.DrawY), 1);
    chk("hs_low_cycles", hs_low, 96);
    chk("hs_first_x_d1", hs_first, 657);
    chk("hs_first_x_d0", hs0_first, 656);
    chk("blank_low_cycles", blank_low, 160);

    for (int f = 0; f < 2; f++) begin
      poke_row(486);
      vs_low = 0;
      run_to(0, 496, 9000);
      chk("vs_low_cycles", vs_low, 1600);
      poke_row(520);
      run_to(0, 0, 5000);
      chk("frame_fs", 32'(vif.frame_start), 1);
      chk("frame_count_n", 32'(vif.frame_count), 32'(f + 1));
    end

    dut.r_frame_count = 16'hFFFF;
    mfc = 16'hFFFF;
    poke_row(520);
    run_to(0, 0, 5000);
    chk("fc_wrap", 32'(vif.frame_count), 0);

    poke_row(200);
    run_to(300, 200, 1000);
    reset = 1'b1;
    tick();
    chk("mid_rst_x", 32'(vif.DrawX), 0);
    chk("mid_rst_y", 32'(vif.DrawY), 0);
    chk("mid_rst_blank", 32'(vif.blank), 0);
    chk("mid_rst_hs", 32'(vif.hs), 1);
    reset = 1'b0;
    #1;
    chk("mid_rel_fs", 32'(vif.frame_start), 1);
    chk("mid_rel_blank", 32'(vif.blank), 1);
    chk("mid_rel_fc", 32'(vif.frame_count), 0);
    since_fs = 0;
    repeat (1000) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter SYNC_DELAY, default 1, the number of vga_clk cycles hs/vs/blank_d lag the DrawX/DrawY they describe (legal 0..4).
REQ-002 SHALL have port vga_clk  input  1  pixel clock (25 MHz); the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port DrawX  output  10  current pixel column 0..799.
REQ-005 SHALL have port DrawY  output  10  current pixel row 0..524.
REQ-006 SHALL have port blank  output  1  display enable, 1 = visible pixel, aligned with DrawX/DrawY.
REQ-007 SHALL have port blank_d  output  1  blank delayed SYNC_DELAY cycles, aligned with a downstream registered colour.
REQ-008 SHALL have port hs  output  1  horizontal sync, active-low, delayed SYNC_DELAY cycles.
REQ-009 SHALL have port vs  output  1  vertical sync, active-low, delayed SYNC_DELAY cycles.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse while (DrawX,DrawY)=(0,0).
REQ-011 SHALL have port frame_count  output  16  completed-frame counter.
REQ-012 SHALL have ports tp_red, tp_green, tp_blue  output  4 each  test-pattern colour.

Function
REQ-013 DrawX SHALL increment each cycle, wrapping 799->0; on that wrap DrawY SHALL increment, wrapping 524->0.
REQ-014 blank SHALL be 1 iff DrawX<640 and DrawY<480, and 0 while reset is high.
REQ-015 Undelayed hs SHALL be 0 iff 656<=DrawX<=751; undelayed vs SHALL be 0 iff 490<=DrawY<=491.
REQ-016 hs, vs and blank_d SHALL be the undelayed values passed through a SYNC_DELAY-deep register shift line; with SYNC_DELAY=0 they are combinational.
REQ-017 frame_count SHALL increment by 1 on the cycle the counters step (799,524)->(0,0), wrapping FFFF->0000.
REQ-018 frame_start SHALL be 1 exactly one cycle per 420000-cycle frame, never while reset is high.
REQ-019 Period: line = 800 cycles, frame = 525 lines = 420000 cycles, exact, no dropped or repeated counts.

Reset
REQ-020 While reset is high at a vga_clk edge: DrawX=0, DrawY=0, frame_count=0, all delay stages hs=1 vs=1 blank_d=0, tp_* = 0.
REQ-021 Reset mid-frame SHALL take effect on the next edge regardless of counter position; the frame SHALL NOT be counted.
REQ-022 The first cycle after reset release SHALL present (0,0), blank=1, frame_start=1.

Configuration
REQ-023 Macro VGA_TESTPAT_EN SHALL enable the test-pattern generator.
REQ-024 With it: 8 vertical bars, bar = DrawX/80 (comparator chain, no divider), colours in order white, yellow, cyan, green, magenta, red, blue, black (each channel F or 0), registered one cycle after DrawX, forced 0 when blank=0.
REQ-025 Without it: tp_red/tp_green/tp_blue ports SHALL still exist and SHALL be constant 4'h0, with no pattern logic.

Structure
REQ-026 A shared package vga_timing_pkg SHALL hold H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, and the bar width 80.
REQ-027 One sub-module vga_axis_counter (parameterised total, with enable, wrap flag, synchronous reset) SHALL be instantiated twice, horizontal and vertical.

Verification
REQ-028 Release reset, run 800 cycles -> DrawX goes 799->0, DrawY goes 0->1 on cycle 800; blank is 0 for DrawX 640..799.
REQ-029 SYNC_DELAY=1, one line -> hs low for exactly 96 cycles, first low cycle when DrawX=657; SYNC_DELAY=0 -> first low when DrawX=656.
REQ-030 Run 2 frames -> vs low for exactly 1600 consecutive cycles per frame; frame_start pulses 420000 cycles apart; frame_count reads 2.
REQ-031 Assert reset 1 cycle at (300,200) -> next edge DrawX=0 DrawY=0 blank=0 hs=1; after release, frame_count is unchanged and the frame restarts at (0,0).
REQ-032 VGA_TESTPAT_EN defined, DrawX=85 visible -> next cycle tp = (F,F,0); DrawX=600 -> (0,0,0); DrawX=700 -> (0,0,0); undefined -> tp always 0.
REQ-033 Force frame_count to FFFF, complete a frame -> frame_count=0000.
